// File: rtl/bundle_issue_if.sv
// Fetch-to-decode bundle issue bus: bundle handshake, flush/stall
// controls and the four per-lane decode outputs.
interface bundle_issue_if;
    logic [127:0] BundleF;
    logic         BundleValidF;
    logic         BundleReadyF;
    logic         FlushF;
    logic         StallD;
    logic         FlushD;
    logic [31:0]  InstrD0;
    logic [31:0]  InstrD1;
    logic [31:0]  InstrD2;
    logic [31:0]  InstrD3;
    logic [3:0]   LaneValidD;
    logic         SplitD;
    logic         EmptyF;

    modport master (
        output BundleF, BundleValidF, FlushF, StallD, FlushD,
        input  BundleReadyF, InstrD0, InstrD1, InstrD2, InstrD3,
               LaneValidD, SplitD, EmptyF
    );

    modport slave (
        input  BundleF, BundleValidF, FlushF, StallD, FlushD,
        output BundleReadyF, InstrD0, InstrD1, InstrD2, InstrD3,
               LaneValidD, SplitD, EmptyF
    );
endinterface

// File: rtl/bundle_issue.sv
// Bundle FIFO feeding four decode lanes. The head bundle issues as one
// group unless an intra-bundle RAW/WAW hazard forces a split, in which
// case the remaining lanes issue on later cycles.
module bundle_issue #(
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          reset,
    bundle_issue_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [127:0]      r_mem [DEPTH];
    logic [PW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count;
    logic [3:0]        r_pend;
    logic [3:0][31:0]  r_instr;
    logic [3:0]        r_lvalid;
    logic              r_split;

    logic [127:0]      w_head;
    logic [PW-1:0]     w_rptr_nx;
    logic [3:0][31:0]  w_lane;
    logic [3:0][4:0]   w_rd, w_rs1, w_rs2;
    logic [3:0]        w_wr, w_use1, w_use2;
    logic [3:0]        w_conf, w_grp, w_pend_nx;
    logic              w_push, w_adv, w_issue, w_pop, w_blocked;

    // Non-empty lane slots of a bundle; an all-zero word is never issued.
    function automatic logic [3:0] f_mask(input logic [127:0] b);
        for (int k = 0; k < 4; k++) f_mask[k] = |b[32*k +: 32];
    endfunction

    assign w_head    = r_mem[r_rptr];
    assign w_rptr_nx = r_rptr + PW'(1);

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_lane
            logic [6:0] w_op;
            assign w_lane[k] = w_head[32*k +: 32];
            assign w_op      = w_lane[k][6:0];
            assign w_rd[k]   = w_lane[k][11:7];
            assign w_rs1[k]  = w_lane[k][19:15];
            assign w_rs2[k]  = w_lane[k][24:20];
            assign w_wr[k]   = (w_op inside {7'b0110111, 7'b0010111, 7'b1101111,
                                             7'b1100111, 7'b0000011, 7'b0010011,
                                             7'b0110011, 7'b0011011, 7'b0111011})
                               && (w_rd[k] != 5'd0);
            assign w_use1[k] = w_op inside {7'b1100111, 7'b1100011, 7'b0000011,
                                            7'b0100011, 7'b0010011, 7'b0110011,
                                            7'b0011011, 7'b0111011};
            assign w_use2[k] = w_op inside {7'b1100011, 7'b0100011,
                                            7'b0110011, 7'b0111011};
        end
    endgenerate

    // Hazard detection against older pending lanes, then the issue group is
    // the pending prefix ending before the first conflicting lane.
    always_comb begin
        w_conf    = '0;
        w_grp     = '0;
        w_blocked = 1'b0;
        for (int j = 1; j < 4; j++) begin
            for (int i = 0; i < j; i++) begin
                if (r_pend[i] && r_pend[j] && w_wr[i] &&
                    ((w_use1[j] && (w_rs1[j] == w_rd[i])) ||
                     (w_use2[j] && (w_rs2[j] == w_rd[i])) ||
                     (w_wr[j]   && (w_rd[j]  == w_rd[i]))))
                    w_conf[j] = 1'b1;
            end
        end
        for (int j = 0; j < 4; j++) begin
            if (w_conf[j]) w_blocked = 1'b1;
            if (r_pend[j] && !w_blocked) w_grp[j] = 1'b1;
        end
    end

    assign bus.BundleReadyF = (r_count < FULL) && !bus.FlushF;
    assign bus.EmptyF       = (r_count == '0);

    assign w_push  = bus.BundleValidF && bus.BundleReadyF;
    assign w_adv   = !bus.StallD && !bus.FlushD && !bus.FlushF && (r_count != '0);
    assign w_issue = w_adv && (r_pend != 4'b0);
    // A head with nothing left pending (including an all-zero bundle) retires.
    assign w_pop   = w_adv && ((r_pend & ~w_grp) == 4'b0);

    // Pending mask for the head: shrink on issue, reload on a new head.
    always_comb begin
        w_pend_nx = r_pend;
        if (bus.FlushF)
            w_pend_nx = 4'b0;
        else if (w_pop)
            w_pend_nx = (r_count == CW'(1)) ? (w_push ? f_mask(bus.BundleF) : 4'b0)
                                            : f_mask(r_mem[w_rptr_nx]);
        else if (w_issue)
            w_pend_nx = r_pend & ~w_grp;
        else if ((r_count == '0) && w_push)
            w_pend_nx = f_mask(bus.BundleF);
    end

    // Bundle storage; data needs no reset since count guards validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= bus.BundleF;
    end

    // FIFO pointers, occupancy and pending mask.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_pend  <= '0;
        end else if (bus.FlushF) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_pend  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= w_rptr_nx;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_pend <= w_pend_nx;
        end
    end

    // Decode-stage output registers: flush clears, stall holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr  <= '0;
            r_lvalid <= '0;
            r_split  <= 1'b0;
        end else if (bus.FlushD || (!bus.StallD && !w_issue)) begin
            r_instr  <= '0;
            r_lvalid <= '0;
            r_split  <= 1'b0;
        end else if (!bus.StallD) begin
            r_instr  <= w_lane;
            r_lvalid <= w_grp;
            r_split  <= (w_grp != r_pend);
        end
    end

    assign bus.InstrD0    = r_instr[0];
    assign bus.InstrD1    = r_instr[1];
    assign bus.InstrD2    = r_instr[2];
    assign bus.InstrD3    = r_instr[3];
    assign bus.LaneValidD = r_lvalid;
    assign bus.SplitD     = r_split;
endmodule

// File: tb/tb_bundle_issue.sv
// Bench for bundle_issue: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the issue rules.
module tb_bundle_issue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bundle_issue_if bus ();

    bundle_issue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference model state
    logic [127:0] mq[$];
    logic [3:0]   m_pend;
    logic [127:0] m_instr;
    logic [3:0]   m_lv;
    logic         m_sp;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_wr(input logic [31:0] w);
        logic [6:0] op = w[6:0];
        return (op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111 ||
                op == 7'b1100111 || op == 7'b0000011 || op == 7'b0010011 ||
                op == 7'b0110011 || op == 7'b0011011 || op == 7'b0111011) && (w[11:7] != 5'd0);
    endfunction

    function automatic bit m_r1(input logic [31:0] w);
        logic [6:0] op = w[6:0];
        return op == 7'b1100111 || op == 7'b1100011 || op == 7'b0000011 || op == 7'b0100011 ||
               op == 7'b0010011 || op == 7'b0110011 || op == 7'b0011011 || op == 7'b0111011;
    endfunction

    function automatic bit m_r2(input logic [31:0] w);
        logic [6:0] op = w[6:0];
        return op == 7'b1100011 || op == 7'b0100011 || op == 7'b0110011 || op == 7'b0111011;
    endfunction

    function automatic logic [3:0] m_mask(input logic [127:0] b);
        logic [3:0] m = '0;
        for (int k = 0; k < 4; k++) if (b[32*k +: 32] != 32'h0) m[k] = 1'b1;
        return m;
    endfunction

    // Walk pending lanes in order, tracking registers written so far.
    function automatic logic [3:0] m_group(input logic [127:0] b, input logic [3:0] pend);
        logic [31:0] written = '0;
        logic [3:0]  g = '0;
        logic [31:0] w;
        for (int j = 0; j < 4; j++) begin
            if (pend[j]) begin
                w = b[32*j +: 32];
                if ((m_r1(w) && written[w[19:15]]) || (m_r2(w) && written[w[24:20]]) ||
                    (m_wr(w) && written[w[11:7]]))
                    break;
                g[j] = 1'b1;
                if (m_wr(w)) written[w[11:7]] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic m_clear();
        mq.delete();
        m_pend  = '0;
        m_instr = '0;
        m_lv    = '0;
        m_sp    = 1'b0;
    endtask

    task automatic m_update();
        bit         push;
        logic [3:0] g;
        push = bus.BundleValidF && (mq.size() < DEPTH) && !bus.FlushF;
        if (bus.FlushF) begin
            mq.delete();
            m_pend = '0;
        end
        if (bus.FlushD) begin
            m_instr = '0; m_lv = '0; m_sp = 1'b0;
        end else if (!bus.StallD) begin
            if (!bus.FlushF && mq.size() > 0 && m_pend != 0) begin
                g       = m_group(mq[0], m_pend);
                m_instr = mq[0];
                m_lv    = g;
                m_sp    = (g != m_pend);
                m_pend  = m_pend & ~g;
            end else begin
                m_instr = '0; m_lv = '0; m_sp = 1'b0;
            end
            if (!bus.FlushF && mq.size() > 0 && m_pend == 0) begin
                void'(mq.pop_front());
                if (mq.size() > 0) m_pend = m_mask(mq[0]);
            end
        end
        if (push) begin
            mq.push_back(bus.BundleF);
            if (mq.size() == 1) m_pend = m_mask(bus.BundleF);
        end
    endtask

    task automatic compare();
        chk("lanevalid", 128'(bus.LaneValidD), 128'(m_lv));
        chk("split",     128'(bus.SplitD),     128'(m_sp));
        chk("instr",     {bus.InstrD3, bus.InstrD2, bus.InstrD1, bus.InstrD0}, m_instr);
        chk("empty",     128'(bus.EmptyF),     128'(mq.size() == 0));
        chk("ready",     128'(bus.BundleReadyF), 128'((mq.size() < DEPTH) && !bus.FlushF));
    endtask

    task automatic step();
        @(posedge clk);
        m_update();
        #1;
        compare();
    endtask

    task automatic drv(input logic v, input logic [127:0] b, input logic ff,
                       input logic sd, input logic fd);
        bus.BundleValidF = v;
        bus.BundleF      = b;
        bus.FlushF       = ff;
        bus.StallD       = sd;
        bus.FlushD       = fd;
    endtask

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [6:0] op;
        if ($urandom_range(0, 11) == 0) return 32'h0;
        case ($urandom_range(0, 10))
            0: op = 7'b0110111;  1: op = 7'b0010111;  2: op = 7'b1101111;
            3: op = 7'b1100111;  4: op = 7'b0000011;  5: op = 7'b0010011;
            6: op = 7'b0110011;  7: op = 7'b0011011;  8: op = 7'b0111011;
            9: op = 7'b1100011;  default: op = 7'b0100011;
        endcase
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), op};
    endfunction

    function automatic logic [127:0] rnd_bundle();
        logic [127:0] b;
        for (int k = 0; k < 4; k++) b[32*k +: 32] = rnd_instr();
        if (b == '0) b[31:0] = addi(1, 0, 1);
        return b;
    endfunction

    logic [127:0] b_dep;
    int           ngrp;

    initial begin
        reset = 1'b0;
        drv(0, '0, 0, 0, 0);
        m_clear();
        #1;
        chk("rst_lanevalid", 128'(bus.LaneValidD), 128'(0));
        chk("rst_instr", {bus.InstrD3, bus.InstrD2, bus.InstrD1, bus.InstrD0}, 128'(0));
        chk("rst_empty", 128'(bus.EmptyF), 128'(1));
        chk("rst_ready", 128'(bus.BundleReadyF), 128'(1));
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // Four independent lanes issue together one edge after the push.
        drv(1, {addi(4, 0, 4), addi(3, 0, 3), addi(2, 0, 2), addi(1, 0, 1)}, 0, 0, 0);
        step();
        drv(0, '0, 0, 0, 0);
        step();
        chk("full_group_lv", 128'(bus.LaneValidD), 128'(4'b1111));
        chk("full_group_split", 128'(bus.SplitD), 128'(0));
        chk("full_group_empty", 128'(bus.EmptyF), 128'(1));

        // RAW hazard between lane0 and lane1 splits the bundle.
        b_dep = {addi(0, 0, 0), addi(0, 0, 0), add(6, 5, 5), addi(5, 0, 1)};
        drv(1, b_dep, 0, 0, 0);
        step();
        drv(0, '0, 0, 0, 0);
        step();
        chk("split1_lv", 128'(bus.LaneValidD), 128'(4'b0001));
        chk("split1_split", 128'(bus.SplitD), 128'(1));
        step();
        chk("split2_lv", 128'(bus.LaneValidD), 128'(4'b1110));
        chk("split2_split", 128'(bus.SplitD), 128'(0));
        chk("split2_empty", 128'(bus.EmptyF), 128'(1));

        // Empty slots are skipped without forcing a split.
        drv(1, {32'h0, addi(2, 0, 2), 32'h0, addi(1, 0, 1)}, 0, 0, 0);
        step();
        drv(0, '0, 0, 0, 0);
        step();
        chk("holes_lv", 128'(bus.LaneValidD), 128'(4'b0101));
        chk("holes_split", 128'(bus.SplitD), 128'(0));

        // Fill under stall: fifth push dropped, then four ordered groups.
        for (int n = 0; n < 5; n++) begin
            drv(1, {addi(4, 0, n), addi(3, 0, n), addi(2, 0, n), addi(1, 0, n + 1)}, 0, 1, 0);
            step();
            if (n == 3) chk("fill_ready", 128'(bus.BundleReadyF), 128'(0));
        end
        drv(0, '0, 0, 0, 0);
        ngrp = 0;
        for (int n = 0; n < 6; n++) begin
            step();
            if (bus.LaneValidD != 0) ngrp++;
        end
        chk("fill_groups", 128'(ngrp), 128'(4));

        // Stall+flush mid-split: outputs clear, remaining lanes survive.
        drv(1, b_dep, 0, 0, 0);
        step();
        drv(0, '0, 0, 0, 0);
        step();
        drv(0, '0, 0, 1, 1);
        step();
        chk("sflush_lv", 128'(bus.LaneValidD), 128'(0));
        drv(0, '0, 0, 0, 0);
        step();
        chk("sflush_resume_lv", 128'(bus.LaneValidD), 128'(4'b1110));

        // Asynchronous reset between edges with three queued bundles.
        drv(1, {addi(4, 0, 4), addi(3, 0, 3), addi(2, 0, 2), addi(1, 0, 1)}, 0, 0, 0);
        step();
        drv(1, {addi(4, 0, 4), addi(3, 0, 3), addi(2, 0, 2), addi(1, 0, 1)}, 0, 1, 0);
        step(); step();
        drv(0, '0, 0, 1, 0);
        #2 reset = 1'b0;
        #1;
        m_clear();
        chk("arst_lv", 128'(bus.LaneValidD), 128'(0));
        chk("arst_empty", 128'(bus.EmptyF), 128'(1));
        compare();
        @(negedge clk) reset = 1'b1;
        drv(0, '0, 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            step();
            chk("arst_noissue", 128'(bus.LaneValidD), 128'(0));
        end

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            drv($urandom_range(0, 9) < 6, rnd_bundle(), $urandom_range(0, 39) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
            step();
        end
        drv(0, '0, 0, 0, 0);
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
